// File: rtl/pwm_measure.sv
// PWM high-time / period meter with valid/ready result handshake, timeout and overrun flags.
// Optional build macro PWM_MEASURE_GLITCH_FILTER_EN inserts a 3-sample stability filter after the synchronizer.
module pwm_measure #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pwm_in,
    input  logic             en,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout,
    output logic             overrun
);

    // state | meaning
    // IDLE  | measurement disabled
    // ARM   | waiting for the first rise; partial period ignored, no timeout
    // HIGH  | counting the high phase
    // LOW   | counting the low phase; next rise completes a measurement
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic sync_ff;
    logic sync_in;
    logic line;
    logic line_d;
    logic rise_q;
    logic fall_q;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic             at_limit;
    logic             done;
    logic             to_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_ff <= 1'b0;
            sync_in <= 1'b0;
            line_d  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_ff <= pwm_in;
            sync_in <= sync_ff;
            line_d  <= line;
            rise_q  <= line & ~line_d;
            fall_q  <= ~line & line_d;
        end
    end

`ifdef PWM_MEASURE_GLITCH_FILTER_EN
    // line only follows sync_in once the current and two previous samples agree
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist <= 2'b00;
        end else begin
            hist <= {hist[0], sync_in};
        end
    end

    assign line = (sync_in == hist[0] && hist[0] == hist[1]) ? sync_in : line_d;
`else
    assign line = sync_in;
`endif

    // Saturating increment keeps the counter at TIMEOUT so it can never wrap
    assign at_limit = (cnt >= TO_VAL);
    assign cnt_inc  = at_limit ? cnt : cnt + ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hcnt_nxt  = hcnt;
        done      = 1'b0;
        to_hit    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            hcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    if (rise_q) begin
                        state_nxt = HIGH;
                        cnt_nxt   = ONE;
                    end
                end
                HIGH: begin
                    if (fall_q) begin
                        state_nxt = LOW;
                        hcnt_nxt  = cnt;
                        cnt_nxt   = cnt_inc;
                    end else if (at_limit) begin
                        state_nxt = ARM;
                        cnt_nxt   = '0;
                        to_hit    = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise_q) begin
                        state_nxt = HIGH;
                        cnt_nxt   = ONE;
                        done      = 1'b1;
                    end else if (at_limit) begin
                        state_nxt = ARM;
                        cnt_nxt   = '0;
                        to_hit    = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A result completing on the handshake edge replaces the accepted one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meas_high   <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= to_hit;
            if (!en) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end else if (done) begin
                if (!meas_valid || meas_ready) begin
                    meas_high   <= hcnt;
                    meas_period <= cnt;
                    meas_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pwm_measure.md
PWM_MEASURE -- requirements
Module: pwm_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the high-time and period counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the number of clk cycles without an edge before a timeout; legal range 4..2^CNT_W-1.
REQ-003 SHALL have port clk  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in  in  1  asynchronous PWM input to be measured.
REQ-006 SHALL have port en  in  1  measurement enable, level-sensitive.
REQ-007 SHALL have port meas_high  out  CNT_W  high time of the last completed period, in clk cycles.
REQ-008 SHALL have port meas_period  out  CNT_W  rise-to-rise period of the last completed period, in clk cycles.
REQ-009 SHALL have port meas_valid  out  1  result available; held until accepted.
REQ-010 SHALL have port meas_ready  in  1  consumer accepts the result when meas_valid and meas_ready are both 1.
REQ-011 SHALL have port timeout  out  1  one-cycle pulse when no edge is seen for TIMEOUT cycles.
REQ-012 SHALL have port overrun  out  1  sticky flag: a result was dropped.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; sync_in denotes the second flop output.
REQ-014 Edge detection SHALL compare sync_in with a one-cycle delayed copy: rise = 1->0 to 1 transition (0 then 1), fall = 1 then 0.
REQ-015 The FSM SHALL have the states IDLE, ARM, HIGH and LOW.
- IDLE -> ARM when en=1.
- ARM -> HIGH on rise; the first, partial period is discarded.
- HIGH -> LOW on fall.
- LOW -> HIGH on rise, which completes a measurement.
REQ-016 On entering HIGH, the counter SHALL load 1 and then increment every cycle in HIGH and LOW.
REQ-017 On fall, the counter value SHALL be latched as the high count.
REQ-018 On rise in LOW, the result SHALL be meas_high = latched high count and meas_period = counter value, with meas_valid=1 on the next edge.
REQ-019 Latency: if pwm_in rises and is captured by the first sync flop at posedge N, meas_valid SHALL be 1 after posedge N+3.
REQ-020 meas_valid, meas_high and meas_period SHALL stay stable while meas_valid=1 and meas_ready=0.
REQ-021 meas_valid SHALL clear on the edge after the handshake, unless a new result loads on that same edge, in which case meas_valid stays 1 with the new data.
REQ-022 When a result completes while meas_valid=1 and meas_ready=0:
- the new result SHALL be dropped;
- the old result SHALL be kept;
- overrun SHALL be set to 1.
REQ-023 If the counter reaches TIMEOUT in HIGH or LOW with no edge:
- timeout SHALL pulse for 1 cycle;
- the FSM SHALL go to ARM;
- the partial period SHALL be discarded.
REQ-024 Timeout SHALL NOT be active in ARM; a constant input waits in ARM indefinitely.
REQ-025 When en=0 in any state:
- the FSM SHALL go to IDLE on the next edge;
- meas_valid SHALL clear;
- overrun SHALL clear;
- the partial measurement SHALL be discarded.
REQ-026 The counter SHALL never wrap; TIMEOUT bounds it below 2^CNT_W.

Reset
REQ-027 When rstn=0, the following SHALL hold immediately:
- FSM=IDLE;
- synchronizer, edge and counter registers = 0;
- meas_high=0, meas_period=0, meas_valid=0, timeout=0, overrun=0.
REQ-028 Reset mid-measurement SHALL discard all state; the first period after release is discarded again (via ARM).

Configuration
REQ-029 Macro PWM_MEASURE_GLITCH_FILTER_EN: when defined, sync_in SHALL pass through a 3-sample majority-stable filter.
- The output changes only after 3 consecutive equal samples.
- This adds 2 cycles of latency, so REQ-019 becomes N+5.
- Results for clean inputs are unchanged.
- Single-cycle pulses are rejected.
REQ-030 When PWM_MEASURE_GLITCH_FILTER_EN is not defined, no filter SHALL exist and every synchronized transition SHALL be measured.

Verification
REQ-031 Periodic PWM (period 16, high 3), en=1, meas_ready=1 -> first result after the 2nd rise; then meas_high=3 and meas_period=16 every 16 cycles; overrun=0.
REQ-032 Same stimulus with meas_ready=0 -> the first result is held; at the next completion overrun=1 and the outputs keep 3/16; meas_ready=1 for one cycle -> meas_valid=0, then the next result arrives.
REQ-033 TIMEOUT=64, pwm_in held high 100 cycles after a rise -> timeout pulses exactly once, 64 cycles after entering HIGH; no meas_valid.
REQ-034 en dropped mid-period, then re-raised -> meas_valid=0 and overrun=0; the first post-enable period is discarded; the 2nd rise yields a correct result.
REQ-035 rstn pulsed low mid-HIGH -> all outputs 0 asynchronously; after release, a period 10 / high 4 input measures 4/10.
REQ-036 Filter defined, one-cycle spike in the low phase of a 16/3 PWM -> results still 3/16; without the macro -> a short-period result is reported.
